// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX register tags and imem status toward the
// controller, pipeline enables and status back from it.
interface pipeline_hazard_ctrl_if #(
   parameter int CNTW = 16
);
   logic [4:0]      RsD;
   logic [4:0]      RtD;
   logic [4:0]      RtE;
   logic            MemtoRegE;
   logic            BranchD;
   logic            BranchTakenD;
   logic            imem_ready;
   logic            pc_en;
   logic            ifid_en;
   logic            ifid_rst;
   logic            idex_flush;
   logic [1:0]      state;
   logic            timeout_err;
   logic [CNTW-1:0] stall_count;

   modport master (
      output RsD, RtD, RtE, MemtoRegE, BranchD, BranchTakenD, imem_ready,
      input  pc_en, ifid_en, ifid_rst, idex_flush, state, timeout_err, stall_count
   );

   modport slave (
      input  RsD, RtD, RtE, MemtoRegE, BranchD, BranchTakenD, imem_ready,
      output pc_en, ifid_en, ifid_rst, idex_flush, state, timeout_err, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush,
// instruction-memory wait with timeout, and a saturating stall counter.
//
// state  | meaning
// S_RUN  | normal issue; Mealy resolution of load-use / branch / imem miss
// S_WAIT | waiting on instruction memory, counting consecutive miss cycles
// S_ERR  | imem timed out; pipeline frozen until reset (2'b11 behaves the same)
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNTW    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] TMO = WCW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_RUN  = 2'b00,
      S_WAIT = 2'b01,
      S_ERR  = 2'b10
   } state_t;

   state_t          r_state;
   logic [WCW-1:0]  r_wait_cnt;
   logic            r_err;
   logic [CNTW-1:0] r_stall;

   state_t          w_next;
   logic [WCW-1:0]  w_wait_nxt;
   logic            w_err_nxt;
   logic            w_lu;
   logic            w_br;
   logic            w_pc_en;
   logic            w_ifid_en;
   logic            w_ifid_rst;
   logic            w_idex_flush;

   assign w_lu = hz.MemtoRegE && (hz.RtE != 5'd0) &&
                 ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
   assign w_br = hz.BranchD && hz.BranchTakenD;

   // State, wait counter and sticky error register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // Stall-cycle counter: counts every edge with the PC held, saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (!w_pc_en && (r_stall != {CNTW{1'b1}})) begin
         r_stall <= r_stall + 1'b1;
      end
   end

   // Next-state and Mealy pipeline controls; reset forces the safe freeze pattern.
   always_comb begin
      w_next       = r_state;
      w_wait_nxt   = r_wait_cnt;
      w_err_nxt    = r_err;
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_ifid_rst   = 1'b1;
      w_idex_flush = 1'b1;
      case (r_state)
         S_RUN: begin
            if (w_lu) begin
               w_ifid_rst   = 1'b0;
            end else if (w_br) begin
               w_pc_en      = 1'b1;
               w_ifid_en    = 1'b1;
               w_idex_flush = 1'b0;
            end else if (!hz.imem_ready) begin
               w_idex_flush = 1'b0;
               w_next       = S_WAIT;
               w_wait_nxt   = WCW'(1);
            end else begin
               w_pc_en      = 1'b1;
               w_ifid_en    = 1'b1;
               w_ifid_rst   = 1'b0;
               w_idex_flush = 1'b0;
            end
         end
         S_WAIT: begin
            w_idex_flush = 1'b0;
            if (hz.imem_ready) begin
               w_pc_en    = 1'b1;
               w_ifid_en  = 1'b1;
               w_ifid_rst = 1'b0;
               w_next     = S_RUN;
               w_wait_nxt = '0;
            end else if (r_wait_cnt == TMO) begin
               w_next    = S_ERR;
               w_err_nxt = 1'b1;
            end else begin
               w_wait_nxt = r_wait_cnt + 1'b1;
            end
         end
         default: begin
            w_next    = S_ERR;
            w_err_nxt = 1'b1;
         end
      endcase
      if (!rst) begin
         w_pc_en      = 1'b0;
         w_ifid_en    = 1'b0;
         w_ifid_rst   = 1'b1;
         w_idex_flush = 1'b1;
      end
   end

   assign hz.pc_en       = w_pc_en;
   assign hz.ifid_en     = w_ifid_en;
   assign hz.ifid_rst    = w_ifid_rst;
   assign hz.idex_flush  = w_idex_flush;
   assign hz.state       = r_state;
   assign hz.timeout_err = r_err;
   assign hz.stall_count = r_stall;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
   localparam int TMO  = 15;
   localparam int CW   = 16;
   localparam int SMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNTW(CW)) hz ();

   pipeline_hazard_ctrl #(.TIMEOUT(TMO), .CNTW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   int n_chk = 0;
   int n_bad = 0;

   // reference model: 0 = running, 1 = waiting on imem, 2 = timed out
   int m_st    = 0;
   int m_wc    = 0;
   int m_err   = 0;
   int m_stall = 0;
   logic e_pc, e_ifen, e_ifrst, e_fl;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit load_use();
      return hz.MemtoRegE && (hz.RtE != 0) && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
   endfunction

   // expected controls as {pc_en, ifid_en, ifid_rst, idex_flush}
   function automatic logic [3:0] model_outs();
      if (!rst)        return 4'b0011;
      if (m_st == 2)   return 4'b0011;
      if (m_st == 1)   return hz.imem_ready ? 4'b1100 : 4'b0010;
      if (load_use())  return 4'b0001;
      if (hz.BranchD && hz.BranchTakenD) return 4'b1110;
      if (!hz.imem_ready) return 4'b0010;
      return 4'b1100;
   endfunction

   task automatic drive(input int rsd, input int rtd, input int rte, input bit me,
                        input bit br, input bit bt, input bit rdy);
      hz.RsD          = 5'(rsd);
      hz.RtD          = 5'(rtd);
      hz.RtE          = 5'(rte);
      hz.MemtoRegE    = me;
      hz.BranchD      = br;
      hz.BranchTakenD = bt;
      hz.imem_ready   = rdy;
   endtask

   task automatic check_all(input string tag);
      {e_pc, e_ifen, e_ifrst, e_fl} = model_outs();
      chk({tag, ".pc_en"},      32'(hz.pc_en),       32'(e_pc));
      chk({tag, ".ifid_en"},    32'(hz.ifid_en),     32'(e_ifen));
      chk({tag, ".ifid_rst"},   32'(hz.ifid_rst),    32'(e_ifrst));
      chk({tag, ".idex_flush"}, 32'(hz.idex_flush),  32'(e_fl));
      chk({tag, ".state"},      32'(hz.state),       32'(m_st));
      chk({tag, ".timeout_err"},32'(hz.timeout_err), 32'(m_err));
      chk({tag, ".stall_count"},32'(hz.stall_count), 32'(m_stall));
   endtask

   // one clock: entered just after a rising edge with rst high
   task automatic cyc(input string tag);
      int n_st, n_wc, n_err;
      #2;
      check_all(tag);
      n_st = m_st; n_wc = m_wc; n_err = m_err;
      if (m_st == 0) begin
         if (!load_use() && !(hz.BranchD && hz.BranchTakenD) && !hz.imem_ready) begin
            n_st = 1; n_wc = 1;
         end
      end else if (m_st == 1) begin
         if (hz.imem_ready) begin
            n_st = 0; n_wc = 0;
         end else if (m_wc == TMO) begin
            n_st = 2; n_err = 1;
         end else begin
            n_wc = m_wc + 1;
         end
      end
      @(posedge clk);
      m_st = n_st; m_wc = n_wc; m_err = n_err;
      if (!e_pc && m_stall < SMAX) m_stall++;
      #1;
   endtask

   // reset asserted between edges, checked before and after an edge, released mid-cycle
   task automatic rst_pulse(input string tag);
      rst = 1'b0;
      #2;
      m_st = 0; m_wc = 0; m_err = 0; m_stall = 0;
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      rst = 1'b1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      rst_pulse("init");

      // load-use, then the stall count shows on the next cycle
      drive(5, 0, 5, 1, 0, 0, 1); cyc("lu");
      drive(0, 0, 0, 0, 0, 0, 1); cyc("lu_after");
      chk("lu_stall_one", 32'(hz.stall_count), 32'd1);

      // $zero never creates a load-use hazard
      drive(0, 0, 0, 1, 0, 0, 1); cyc("zero_excl");
      drive(3, 0, 0, 1, 0, 0, 1); cyc("zero_excl_rt");

      // load-use outranks a taken branch, branch acts next cycle
      drive(5, 0, 5, 1, 1, 1, 1); cyc("prio_lu");
      drive(5, 0, 5, 0, 1, 1, 1); cyc("prio_br");
      drive(0, 0, 0, 0, 1, 1, 0); cyc("br_miss");
      drive(0, 7, 7, 1, 0, 0, 1); cyc("lu_rt");

      // three-cycle imem miss
      rst_pulse("pre_miss");
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("miss");
      drive(0, 0, 0, 0, 0, 0, 1); cyc("miss_end");
      cyc("miss_run");
      chk("miss_stall", 32'(hz.stall_count), 32'd3);

      // timeout after 16 edges; ERR is sticky
      rst_pulse("pre_tmo");
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < TMO + 1; i++) cyc("tmo_wait");
      chk("tmo_state", 32'(hz.state), 32'd2);
      chk("tmo_err", 32'(hz.timeout_err), 32'd1);
      drive(0, 0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) cyc("tmo_sticky");

      // asynchronous reset in the middle of WAIT
      rst_pulse("pre_async");
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc("async_a"); cyc("async_b");
      rst_pulse("async_wait");
      drive(0, 0, 0, 0, 0, 0, 1); cyc("async_resume");

      // random traffic with occasional long misses and resets
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst_pulse("rnd_rst");
         end else if ($urandom_range(0, 149) == 0) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            for (int j = 0; j < TMO + 2; j++) cyc("rnd_burst");
         end else begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            cyc("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max consecutive IMEM_WAIT cycles before error.
REQ-002 SHALL have parameter CNTW, default 16, width of stall_count.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports RsD, RtD  input  5 each  source registers of instruction in ID.
REQ-006 SHALL have port RtE  input  5  destination register of instruction in EX.
REQ-007 SHALL have port MemtoRegE  input  1  EX instruction is a load.
REQ-008 SHALL have ports BranchD, BranchTakenD  input  1 each  branch in ID; comparator result.
REQ-009 SHALL have port imem_ready  input  1  instruction memory data valid this cycle.
REQ-010 SHALL have ports pc_en, ifid_en, ifid_rst, idex_flush  output  1 each  PC enable; IF/ID enable; IF/ID synchronous clear; ID/EX bubble.
REQ-011 SHALL have ports state  output  2  FSM state; timeout_err  output  1  sticky error; stall_count  output  CNTW  stall-cycle counter.

Function
REQ-012 SHALL implement states RUN=2'b00, WAIT=2'b01, ERR=2'b10; 2'b11 unreachable, decodes as ERR.
REQ-013 SHALL define hazard lu = MemtoRegE & (RtE != 0) & (RtE == RsD | RtE == RtD).
REQ-014 SHALL, in RUN, drive pc_en, ifid_en, ifid_rst, idex_flush combinationally (Mealy), with priority lu > branch > imem miss > normal.
REQ-015 SHALL, in RUN with lu=1, drive pc_en=0, ifid_en=0, ifid_rst=0, idex_flush=1; remain RUN; branch and imem_ready ignored this cycle.
REQ-016 SHALL, in RUN with lu=0 and BranchD & BranchTakenD, drive pc_en=1, ifid_en=1, ifid_rst=1, idex_flush=0; remain RUN even if imem_ready=0.
REQ-017 SHALL, in RUN with no lu, no taken branch, imem_ready=0, drive pc_en=0, ifid_en=0, ifid_rst=1, idex_flush=0; next state WAIT; wait counter loads 1.
REQ-018 SHALL, in RUN otherwise, drive pc_en=1, ifid_en=1, ifid_rst=0, idex_flush=0.
REQ-019 SHALL, in WAIT with imem_ready=0, drive pc_en=0, ifid_en=0, ifid_rst=1, idex_flush=0; ignore lu and branch inputs; increment wait counter.
REQ-020 SHALL, in WAIT with imem_ready=1, drive pc_en=1, ifid_en=1, ifid_rst=0, idex_flush=0; next state RUN; wait counter cleared.
REQ-021 SHALL, in WAIT when wait counter equals TIMEOUT and imem_ready=0, transition to ERR and set timeout_err=1 on that edge.
REQ-022 SHALL, in ERR, drive pc_en=0, ifid_en=0, ifid_rst=1, idex_flush=1; remain in ERR until reset; timeout_err stays 1.
REQ-023 SHALL increment stall_count on each rising edge where pc_en=0 and rst=1, saturating at all-ones.
REQ-024 SHALL size wait counter to hold TIMEOUT without overflow.
REQ-025 SHALL present state as the registered FSM state, never a next-state value.

Reset
REQ-026 SHALL, while rst=0, force state=RUN, wait counter=0, timeout_err=0, stall_count=0 asynchronously.
REQ-027 SHALL, while rst=0, drive pc_en=0, ifid_en=0, ifid_rst=1, idex_flush=1 regardless of other inputs.
REQ-028 SHALL, on rst rising while in WAIT or ERR, resume in RUN with all counters zero on the first clock edge after release.

Verification
REQ-029 SHALL verify load-use: MemtoRegE=1, RtE=5, RsD=5, imem_ready=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_count 0->1; state stays 00.
REQ-030 SHALL verify $zero exclusion: MemtoRegE=1, RtE=0, RsD=0 -> pc_en=1, idex_flush=0, stall_count unchanged.
REQ-031 SHALL verify priority: lu true with BranchD=BranchTakenD=1 -> ifid_rst=0, idex_flush=1; next cycle lu=0, branch still taken -> ifid_rst=1, pc_en=1.
REQ-032 SHALL verify imem miss: imem_ready=0 for 3 cycles then 1 -> state 00,01,01,01,00; pc_en low 3 cycles; stall_count=3.
REQ-033 SHALL verify timeout: TIMEOUT=15, imem_ready held 0 -> state=10 and timeout_err=1 after 16th edge; imem_ready=1 afterward keeps ERR.
REQ-034 SHALL verify async reset: rst=0 mid-WAIT between clock edges -> state=00, stall_count=0, ifid_rst=1 immediately, without a clock edge.
